// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one unified memory port between instruction fetch and data access.
// Define MEM_ARB_RR_EN for round-robin ties instead of D priority with IF starvation guard.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    logic   owner_d;
    logic   grant_d;
    logic   any_req;

    assign any_req = if_req | d_req;

`ifndef MEM_ARB_RR_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;
    logic          starved;

    assign starved = (starve_cnt == CW'(STARVE_LIMIT));

    always_comb begin
        grant_d = d_req & ~(if_req & starved);
    end

    // Counts D grants that made a waiting IF lose; any IF grant resets it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (!if_req || !grant_d) begin
                starve_cnt <= '0;
            end else if (!starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`else
    // On a tie, owner_d still names the last requester granted.
    always_comb begin
        grant_d = d_req & (~if_req | ~owner_d);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        state   <= ACCESS;
                        busy    <= 1'b1;
                        owner_d <= grant_d;
                        mem_we  <= grant_d & d_we;
                        if (grant_d) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_addr  <= if_addr;
                        end
                    end
                end
                ACCESS: begin
                    state  <= DONE;
                    mem_we <= 1'b0;
                    if (owner_d) begin
                        d_rdata <= mem_rdata;
                        d_ack   <= 1'b1;
                    end else begin
                        if_rdata <= mem_rdata;
                        if_ack   <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    if_ack <= 1'b0;
                    d_ack  <= 1'b0;
                    busy   <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
